// File: rtl/lab_fxyz_pipe_if.sv
// Stream interface of the fx/fy/fz scaling stage. The input side carries L/a/b with a
// valid/ready pair, and the output side carries fy/fx/fz plus per-sample flags.
interface lab_fxyz_pipe_if #(
    parameter int DSIZE = 16,
    parameter int LW    = 7,
    parameter int AW    = 10,
    parameter int BW    = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LW-1:0]           CIE_L;
    logic signed [AW-1:0]    CIE_A;
    logic signed [BW-1:0]    CIE_B;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DSIZE+2:0] FY;
    logic signed [DSIZE+2:0] FX;
    logic signed [DSIZE+2:0] FZ;
    logic                    neg_x;
    logic                    neg_z;
    logic                    sat;

    modport master (
        output in_valid, CIE_L, CIE_A, CIE_B, out_ready,
        input  in_ready, out_valid, FY, FX, FZ, neg_x, neg_z, sat
    );

    modport slave (
        input  in_valid, CIE_L, CIE_A, CIE_B, out_ready,
        output in_ready, out_valid, FY, FX, FZ, neg_x, neg_z, sat
    );
endinterface

// File: rtl/lab_fxyz_pipe.sv
// Three-stage pipeline that computes fy=(L+16)/116, fx=fy+a/500 and fz=fy-b/200 in signed
// Q2.DSIZE. All stages advance on one shared enable, and the output saturates with an optional clamp.
module lab_fxyz_pipe #(
    parameter int DSIZE = 16,
    parameter int LW    = 7,
    parameter int AW    = 10,
    parameter int BW    = 9,
    parameter bit CLAMP = 1'b1
) (
    input logic             clock,
    input logic             rst_n,
    lab_fxyz_pipe_if.slave  bus
);
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam longint unsigned ONE  = 64'd1 << DSIZE;
    localparam longint unsigned M116 = (ONE + 64'd58)  / 64'd116;
    localparam longint unsigned M500 = (ONE + 64'd250) / 64'd500;
    localparam longint unsigned M200 = (ONE + 64'd100) / 64'd200;

    localparam int OW  = DSIZE + 3;
    localparam int PLW = LW + 1 + DSIZE;
    localparam int PAW = AW + DSIZE + 1;
    localparam int PBW = BW + DSIZE + 1;
    // Two guard bits cover the sum or difference of an unsigned and a signed product.
    localparam int SW  = max3(PLW, PAW, PBW) + 2;

    localparam logic [PLW-1:0]        K116 = PLW'(M116);
    localparam logic signed [PAW-1:0] K500 = PAW'(M500);
    localparam logic signed [PBW-1:0] K200 = PBW'(M200);
    localparam logic signed [SW-1:0]  OMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0]  OMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic adv;
    logic accept;
    logic v1, v2, v3;

    assign adv           = !v3 || bus.out_ready;
    assign accept        = bus.in_valid && adv;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v3;

    // Stage 1: full-precision products
    logic [LW:0]              l16;
    logic signed [PAW-1:0]    a_ext;
    logic signed [PBW-1:0]    b_ext;
    logic [PLW-1:0]           p_l;
    logic signed [PAW-1:0]    p_a;
    logic signed [PBW-1:0]    p_b;

    assign l16   = {1'b0, bus.CIE_L} + (LW+1)'(16);
    assign a_ext = PAW'(bus.CIE_A);
    assign b_ext = PBW'(bus.CIE_B);

    // Stage 2: wide sums
    logic signed [SW-1:0] l_sum, a_sum, b_sum;
    logic signed [SW-1:0] sy, sx, sz;

    assign l_sum = SW'(p_l);
    assign a_sum = SW'(p_a);
    assign b_sum = SW'(p_b);

    // NOTE: datapath registers carry no reset; the valid bits alone decide what reaches the output.
    always_ff @(posedge clock) begin
        if (adv) begin
            p_l <= PLW'(l16) * K116;
            p_a <= a_ext * K500;
            p_b <= b_ext * K200;
            sy  <= l_sum;
            sx  <= l_sum + a_sum;
            sz  <= l_sum - b_sum;
        end
    end

    // Stage 3: saturate, flag and optionally clamp
    function automatic logic signed [OW-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > OMAX) return OMAX[OW-1:0];
        if (v < OMIN) return OMIN[OW-1:0];
        return v[OW-1:0];
    endfunction

    logic signed [OW-1:0] y_res, x_res, z_res;
    logic                 any_ovf;
    logic                 x_neg, z_neg;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        x_neg   = sx[SW-1];
        z_neg   = sz[SW-1];
        any_ovf = (sy > OMAX) || (sy < OMIN) ||
                  (sx > OMAX) || (sx < OMIN) ||
                  (sz > OMAX) || (sz < OMIN);
        y_res   = saturate(sy);
        x_res   = saturate(sx);
        z_res   = saturate(sz);
        if (CLAMP && x_neg) x_res = '0;
        if (CLAMP && z_neg) z_res = '0;
    end

    // NOTE: valid bits and outputs use non-blocking assignments and reset asynchronously.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            bus.FY    <= '0;
            bus.FX    <= '0;
            bus.FZ    <= '0;
            bus.neg_x <= 1'b0;
            bus.neg_z <= 1'b0;
            bus.sat   <= 1'b0;
        end else if (adv) begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
            if (v2) begin
                bus.FY    <= y_res;
                bus.FX    <= x_res;
                bus.FZ    <= z_res;
                bus.neg_x <= x_neg;
                bus.neg_z <= z_neg;
                bus.sat   <= any_ovf;
            end
        end
    end
endmodule

// File: tb/tb_lab_fxyz_pipe.sv
// Directed bench: a clamping and a non-clamping instance run side by side on the same input
// stream. Expected values come from hand-computed constants and a small arithmetic model.
module tb_lab_fxyz_pipe;
    localparam int DSIZE = 16;
    localparam int LW    = 7;
    localparam int AW    = 10;
    localparam int BW    = 9;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    lab_fxyz_pipe_if #(.DSIZE(DSIZE), .LW(LW), .AW(AW), .BW(BW)) bus_c ();
    lab_fxyz_pipe_if #(.DSIZE(DSIZE), .LW(LW), .AW(AW), .BW(BW)) bus_n ();

    assign bus_n.in_valid  = bus_c.in_valid;
    assign bus_n.CIE_L     = bus_c.CIE_L;
    assign bus_n.CIE_A     = bus_c.CIE_A;
    assign bus_n.CIE_B     = bus_c.CIE_B;
    assign bus_n.out_ready = bus_c.out_ready;

    lab_fxyz_pipe #(.DSIZE(DSIZE), .LW(LW), .AW(AW), .BW(BW), .CLAMP(1'b1)) dut_c (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus_c)
    );

    lab_fxyz_pipe #(.DSIZE(DSIZE), .LW(LW), .AW(AW), .BW(BW), .CLAMP(1'b0)) dut_n (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    always #5 clock = ~clock;

    int l_v [8] = '{50, 127, 0, 75, 10, 99, 33, 64};
    int a_v [8] = '{20, 511, -512, -100, 300, -1, 0, -250};
    int b_v [8] = '{-30, -256, 255, 50, 120, -1, 200, -200};

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int l, input int a, input int b);
        bus_c.in_valid = 1'b1;
        bus_c.CIE_L    = LW'(l);
        bus_c.CIE_A    = AW'(a);
        bus_c.CIE_B    = BW'(b);
    endtask

    task automatic model(input int l, input int a, input int b,
                         output int fy, output int fx, output int fz);
        fy = (l + 16) * 565;
        fx = fy + a * 131;
        fz = fy - b * 328;
    endtask

    task automatic check_sample(input string tag, input int idx);
        int fy, fx, fz;
        model(l_v[idx], a_v[idx], b_v[idx], fy, fx, fz);
        check({tag, "_valid"}, bus_c.out_valid, 1);
        check({tag, "_fy"}, bus_c.FY, fy);
        check({tag, "_fx_c"}, bus_c.FX, (fx < 0) ? 0 : fx);
        check({tag, "_fz_c"}, bus_c.FZ, (fz < 0) ? 0 : fz);
        check({tag, "_fx_n"}, bus_n.FX, fx);
        check({tag, "_fz_n"}, bus_n.FZ, fz);
        check({tag, "_negx"}, bus_c.neg_x, (fx < 0) ? 1 : 0);
        check({tag, "_negz"}, bus_c.neg_z, (fz < 0) ? 1 : 0);
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_ovalid"}, bus_c.out_valid, 0);
        check({tag, "_iready"}, bus_c.in_ready, 1);
        check({tag, "_fy"}, bus_c.FY, 0);
        check({tag, "_fx"}, bus_n.FX, 0);
        check({tag, "_fz"}, bus_n.FZ, 0);
        check({tag, "_flags"}, {bus_n.neg_x, bus_n.neg_z, bus_n.sat}, 0);
    endtask

    // Drives one sample and checks that it surfaces exactly three cycles after acceptance.
    task automatic run_one(input string tag, input int l, input int a, input int b);
        drive(l, a, b);
        step();
        bus_c.in_valid = 1'b0;
        check({tag, "_lat1"}, bus_c.out_valid, 0);
        step();
        check({tag, "_lat2"}, bus_c.out_valid, 0);
        step();
        check({tag, "_lat3"}, bus_c.out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_c.in_valid  = 1'b0;
        bus_c.CIE_L     = '0;
        bus_c.CIE_A     = '0;
        bus_c.CIE_B     = '0;
        bus_c.out_ready = 1'b1;

        #2;
        check_zero_state("reset");
        #10 rst_n = 1'b1;
        step();

        // L=100, a=0, b=0 -> 1.0 everywhere
        run_one("t1", 100, 0, 0);
        check("t1_fy", bus_c.FY, 65540);
        check("t1_fx", bus_c.FX, 65540);
        check("t1_fz", bus_c.FZ, 65540);
        check("t1_flags", {bus_c.neg_x, bus_c.neg_z, bus_c.sat}, 0);
        step();
        check("t1_drain", bus_c.out_valid, 0);

        // L=0, a=100, b=100 -> fz negative
        run_one("t2", 0, 100, 100);
        check("t2_fy", bus_c.FY, 9040);
        check("t2_fx", bus_c.FX, 22140);
        check("t2_fz_clamp", bus_c.FZ, 0);
        check("t2_fz_noclamp", bus_n.FZ, -23760);
        check("t2_negz_c", bus_c.neg_z, 1);
        check("t2_negz_n", bus_n.neg_z, 1);
        check("t2_negx", bus_c.neg_x, 0);
        check("t2_sat", bus_c.sat, 0);
        step();

        // Most negative a and b
        run_one("t3", 100, 10'h200, 9'h100);
        check("t3_fx_noclamp", bus_n.FX, -1532);
        check("t3_fx_clamp", bus_c.FX, 0);
        check("t3_negx_c", bus_c.neg_x, 1);
        check("t3_negx_n", bus_n.neg_x, 1);
        check("t3_fz", bus_c.FZ, 149508);
        check("t3_fz_n", bus_n.FZ, 149508);
        check("t3_sat", bus_n.sat, 0);
        step();

        // Back-to-back stream with random backpressure
        begin
            int sent = 0;
            int rcvd = 0;
            logic stall_prev = 1'b0;
            logic signed [63:0] h_fy = '0, h_fx = '0, h_fz = '0;
            for (int cyc = 0; cyc < 400 && rcvd < 8; cyc++) begin
                bus_c.out_ready = ($urandom_range(0, 2) != 0);
                if (sent < 8) drive(l_v[sent], a_v[sent], b_v[sent]);
                else bus_c.in_valid = 1'b0;
                #1;
                check("s_in_ready", bus_c.in_ready, !bus_c.out_valid || bus_c.out_ready);
                if (stall_prev) begin
                    check("s_hold_valid", bus_c.out_valid, 1);
                    check("s_hold_fy", bus_c.FY, h_fy);
                    check("s_hold_fx", bus_n.FX, h_fx);
                    check("s_hold_fz", bus_n.FZ, h_fz);
                end
                if (bus_c.out_valid && bus_c.out_ready) begin
                    check_sample("s_out", rcvd);
                    rcvd++;
                end
                stall_prev = bus_c.out_valid && !bus_c.out_ready;
                h_fy = bus_c.FY;
                h_fx = bus_n.FX;
                h_fz = bus_n.FZ;
                if (bus_c.in_valid && bus_c.in_ready) sent++;
                step();
            end
            check("s_received", rcvd, 8);
            check("s_sent", sent, 8);
        end
        bus_c.in_valid  = 1'b0;
        bus_c.out_ready = 1'b1;
        step();
        check("s_empty", bus_c.out_valid, 0);

        // Fill the pipeline, stall for 10 cycles, then release
        bus_c.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(l_v[i], a_v[i], b_v[i]);
            step();
        end
        drive(l_v[3], a_v[3], b_v[3]);
        for (int i = 0; i < 10; i++) begin
            check("f_in_ready", bus_c.in_ready, 0);
            check_sample("f_stall", 0);
            step();
        end
        bus_c.out_ready = 1'b1;
        #1;
        check("f_release_ready", bus_c.in_ready, 1);
        check_sample("f_q0", 0);
        step();
        bus_c.in_valid = 1'b0;
        check_sample("f_q1", 1);
        step();
        check_sample("f_q2", 2);
        step();
        check_sample("f_new", 3);
        step();
        check("f_drain", bus_c.out_valid, 0);

        // Asynchronous reset with three samples in flight
        for (int i = 4; i < 7; i++) begin
            drive(l_v[i], a_v[i], b_v[i]);
            step();
        end
        bus_c.in_valid = 1'b0;
        check("r_full", bus_c.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_zero_state("r_async");
        step();
        check_zero_state("r_held");
        #3 rst_n = 1'b1;
        step();
        check("r_no_ghost", bus_c.out_valid, 0);
        run_one("r_first", l_v[7], a_v[7], b_v[7]);
        check_sample("r_first", 7);
        step();
        check("r_drain", bus_c.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
